// File: rtl/key_pulse_conditioner_pkg.sv
// Shared types and default timing constants for the key conditioning front end.
package key_pulse_conditioner_pkg;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_WAIT = 2'd3
    } lane_state_e;

    // 25 ms sample period at 50 MHz; 2 samples to settle, 1 s for a long hold.
    localparam int SAMPLE_DIV_50MHZ_25MS  = 1250000;
    localparam int DEFAULT_STABLE_SAMPLES = 2;
    localparam int DEFAULT_HOLD_SAMPLES   = 40;

endpackage

// File: rtl/key_debounce_lane.sv
// One key lane: two-flop synchroniser, tick-paced debounce FSM, press/release/hold pulses.
module key_debounce_lane
    import key_pulse_conditioner_pkg::*;
#(
    parameter int STABLE_SAMPLES = DEFAULT_STABLE_SAMPLES,
    parameter int HOLD_SAMPLES   = DEFAULT_HOLD_SAMPLES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sample_tick,
    input  logic key_raw,
    output logic level,
    output logic press_pulse,
    output logic release_pulse,
    output logic hold_pulse
);

    localparam logic [3:0] STABLE_N = 4'(STABLE_SAMPLES);
    localparam logic [7:0] HOLD_N   = 8'(HOLD_SAMPLES);

    logic [1:0]  sync_r;
    lane_state_e state_r;
    logic [3:0]  cnt_r;
    logic [7:0]  hold_cnt_r;
    logic        level_r;
    logic        press_r;
    logic        release_r;
    logic        hold_r;
    logic        pressed_s;

    // Raw key is active-low; the synchronised copy is inverted to active-high.
    assign pressed_s = ~sync_r[1];

    // Synchroniser, lane state machine and registered pulse/level outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_r     <= 2'b11;
            state_r    <= IDLE;
            cnt_r      <= 4'd0;
            hold_cnt_r <= 8'd0;
            level_r    <= 1'b0;
            press_r    <= 1'b0;
            release_r  <= 1'b0;
            hold_r     <= 1'b0;
        end else begin
            sync_r    <= {sync_r[0], key_raw};
            press_r   <= 1'b0;
            release_r <= 1'b0;
            hold_r    <= 1'b0;
            if (sample_tick) begin
                case (state_r)
                    IDLE: begin
                        if (pressed_s && (STABLE_N == 4'd1)) begin
                            state_r    <= PRESSED;
                            hold_cnt_r <= 8'd0;
                            press_r    <= 1'b1;
                            level_r    <= 1'b1;
                        end else if (pressed_s) begin
                            state_r <= PRESS_WAIT;
                            cnt_r   <= 4'd1;
                        end else begin
                            cnt_r <= 4'd0;
                        end
                    end
                    PRESS_WAIT: begin
                        if (pressed_s && (cnt_r == STABLE_N - 4'd1)) begin
                            state_r    <= PRESSED;
                            cnt_r      <= 4'd0;
                            hold_cnt_r <= 8'd0;
                            press_r    <= 1'b1;
                            level_r    <= 1'b1;
                        end else if (pressed_s) begin
                            cnt_r <= cnt_r + 4'd1;
                        end else begin
                            state_r <= IDLE;
                            cnt_r   <= 4'd0;
                        end
                    end
                    PRESSED: begin
                        // Hold counter saturates, so the hold pulse fires once per press.
                        if (pressed_s && (hold_cnt_r < HOLD_N)) begin
                            hold_cnt_r <= hold_cnt_r + 8'd1;
                            hold_r     <= (hold_cnt_r == HOLD_N - 8'd1);
                        end else if (pressed_s) begin
                            hold_cnt_r <= hold_cnt_r;
                        end else if (STABLE_N == 4'd1) begin
                            state_r    <= IDLE;
                            cnt_r      <= 4'd0;
                            hold_cnt_r <= 8'd0;
                            release_r  <= 1'b1;
                            level_r    <= 1'b0;
                        end else begin
                            state_r <= RELEASE_WAIT;
                            cnt_r   <= 4'd1;
                        end
                    end
                    RELEASE_WAIT: begin
                        if (pressed_s) begin
                            state_r <= PRESSED;
                            cnt_r   <= 4'd0;
                        end else if (cnt_r == STABLE_N - 4'd1) begin
                            state_r    <= IDLE;
                            cnt_r      <= 4'd0;
                            hold_cnt_r <= 8'd0;
                            release_r  <= 1'b1;
                            level_r    <= 1'b0;
                        end else begin
                            cnt_r <= cnt_r + 4'd1;
                        end
                    end
                    default: begin
                        state_r <= IDLE;
                        cnt_r   <= 4'd0;
                        level_r <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign level         = level_r;
    assign press_pulse   = press_r;
    assign release_pulse = release_r;
    assign hold_pulse    = hold_r;

endmodule

// File: rtl/key_pulse_conditioner.sv
// Key front end: shared debounce sample divider feeding one debounce lane per key.
module key_pulse_conditioner
    import key_pulse_conditioner_pkg::*;
#(
    parameter int NUM_KEYS       = 3,
    parameter int SAMPLE_DIV     = SAMPLE_DIV_50MHZ_25MS,
    parameter int STABLE_SAMPLES = DEFAULT_STABLE_SAMPLES,
    parameter int HOLD_SAMPLES   = DEFAULT_HOLD_SAMPLES
) (
    input  logic                CLOCK_50,
    input  logic                key_reset,
    input  logic [NUM_KEYS-1:0] key_in,
    output logic [NUM_KEYS-1:0] key_level,
    output logic [NUM_KEYS-1:0] key_press_pulse,
    output logic [NUM_KEYS-1:0] key_release_pulse,
    output logic [NUM_KEYS-1:0] key_hold_pulse,
    output logic                sample_tick
);

    localparam int               DIV_W    = $clog2(SAMPLE_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SAMPLE_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);
    localparam logic [DIV_W-1:0] DIV_ZERO = DIV_W'(0);

    logic [DIV_W-1:0] div_r;
    logic             tick_r;

    // Free-running sample divider; the strobe is high the cycle after the last count.
    always_ff @(posedge CLOCK_50) begin
        if (!key_reset) begin
            div_r  <= DIV_ZERO;
            tick_r <= 1'b0;
        end else if (div_r == DIV_LAST) begin
            div_r  <= DIV_ZERO;
            tick_r <= 1'b1;
        end else begin
            div_r  <= div_r + DIV_ONE;
            tick_r <= 1'b0;
        end
    end

    assign sample_tick = tick_r;

    for (genvar g = 0; g < NUM_KEYS; g++) begin : g_lane
        key_debounce_lane #(
            .STABLE_SAMPLES(STABLE_SAMPLES),
            .HOLD_SAMPLES  (HOLD_SAMPLES)
        ) u_lane (
            .clk          (CLOCK_50),
            .rst_n        (key_reset),
            .sample_tick  (tick_r),
            .key_raw      (key_in[g]),
            .level        (key_level[g]),
            .press_pulse  (key_press_pulse[g]),
            .release_pulse(key_release_pulse[g]),
            .hold_pulse   (key_hold_pulse[g])
        );
    end

endmodule
